control_mc: RTL and testbench
=============================

Name: control_mc

Overview:
- Multi-cycle successor to the single-cycle opcode decoder in the cpu32 core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states with a ready handshake to a variable-latency memory.
- Latches the decoded control word once per instruction.
- Adds a parametrised memory-wait timeout, a sticky fault state and a run/halt input.
- Drives the same datapath select lines as the existing core, plus IR/PC write enables and memory request strobes.

Parameters:
- OPW, 4, opcode width; opcodes 0..5 are defined, all other values are illegal.
- NZ_BIT, 3, opfunc bit index selecting branch-if-nonzero (1) or branch-if-zero (0).
- LINK_EN, 1, 1 = branch ops write pc+4 to the destination register; 0 = no link write.
- TMO, 255, maximum memory wait cycles before fault; 0 disables the timeout.
- TW, 8, timeout counter width; must satisfy 2^TW > TMO.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = allow a new fetch; sampled only in FETCH before a request is issued
- opcode  in  OPW  IR opcode field, valid from DECODE onward
- opfunc  in  4  IR function field
- ctl_adata_zero  in  1  1 = (adata == 0)
- mem_rdy  in  1  memory completes the current request this cycle
- ctl_mem_req  out  1  memory request strobe
- ctl_mem_ifetch  out  1  1 = address from pc, 0 = address from alu
- ctl_ir_we  out  1  load instruction register
- ctl_pc_we  out  1  update pc
- ctl_alu_pc  out  1  0 = adata, 1 = pc+4 onto alu.left
- ctl_alu_imm  out  1  0 = bdata, 1 = signed imm16
- ctl_regs_we  out  1  register file write
- ctl_ram_we  out  1  memory write (qualifies ctl_mem_req)
- ctl_alu_altdest  out  1  0 = daddr is opd, 1 = daddr is opb
- ctl_wdata_src  out  2  00 = alu, 01 = ram, 10 = pc+4, 11 = 0
- ctl_branch_ind  out  1  0 = relative branch, 1 = indirect branch
- ctl_branch_taken  out  1  0 = pc+4, 1 = branch target
- ctl_fault  out  1  sticky fault flag
- state  out  3  debug: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5

Behaviour:
- Reset (async, rst_n low): state=FETCH, latched control word=0, timeout count=0, ctl_fault=0. All enables and strobes are 0 while rst_n is low. A reset mid-instruction abandons it with no write.
- Datapath select outputs come from a control word latched in DECODE from opcode:
  - op0 ALU reg: regs_we.
  - op1 ALU imm: alu_imm, regs_we, altdest.
  - op2 LW: alu_imm, regs_we, altdest, wdata_src=01.
  - op3 SW: alu_imm, ram_we.
  - op4 B rel16: alu_pc, alu_imm, altdest, branch, wdata_src=10.
  - op5 B Rb: alu_pc, altdest, branch, wdata_src=10.
  - Illegal opcode: flagged.
- Enables and strobes are combinational from state plus the latched word. The select fields hold their value from EXEC through WB.
- FETCH:
  - If run=0: no request; remain in FETCH.
  - Otherwise: mem_req=1, mem_ifetch=1. On mem_rdy: ir_we=1, go to DECODE.
- DECODE: latch the control word, go to EXEC. Illegal opcode goes to FAULT instead.
- EXEC:
  - ALU ops: go to WB.
  - LW/SW: go to MEM.
  - Branch: pc_we=1, branch_ind=opcode[0], branch_taken=(adata_zero != opfunc[NZ_BIT]), regs_we=LINK_EN, then FETCH.
- MEM:
  - mem_req=1, mem_ifetch=0; ram_we=1 for SW.
  - On mem_rdy: LW goes to WB; SW asserts pc_we=1 and goes to FETCH.
- WB: regs_we=1, pc_we=1, go to FETCH.
- regs_we and ram_we are asserted only in the states listed above; they are never asserted in FETCH, DECODE or FAULT.
- Timeout:
  - The counter runs while mem_req=1 and mem_rdy=0. It clears when mem_rdy is seen and on every state change.
  - When the count reaches TMO (TMO>0) without mem_rdy, go to FAULT.
  - If mem_rdy arrives in the same cycle the count reaches TMO, mem_rdy wins.
- FAULT: ctl_fault=1; all enables and strobes are 0. Stays in FAULT until reset; run is ignored.
- run=0 never aborts a request already issued; a request is held until mem_rdy arrives or the timeout fires.
- CPI: ALU op 4+f cycles, LW 5+f+m, SW 4+f+m, branch 3+f, where f and m are the FETCH and MEM wait cycles.

Test Plan:
- Reset released, run=1, mem_rdy=1, opcode=0 → states 0,1,2,4,0. regs_we=1 and pc_we=1 only in cycle 4. wdata_src=00.
- LW (opcode=2) with mem_rdy low 3 cycles in MEM → mem_req held 4 cycles, ram_we=0. WB then has regs_we=1, wdata_src=01. Total 8 cycles with f=0.
- Branch opcode=4, opfunc=4'b1000, adata_zero=0 → EXEC has taken=1, pc_we=1, regs_we=1, ind=0. Repeat with adata_zero=1 → taken=0.
- TMO=4, mem_rdy held 0 in FETCH → FAULT entered after 4 wait cycles, fault=1, no ir_we. A later mem_rdy=1 has no effect until rst_n pulses.
- opcode=4'hF → DECODE to FAULT, no regs_we/ram_we/pc_we ever asserted.
- SW in MEM, rst_n dropped asynchronously mid-cycle → ram_we and mem_req fall immediately. state=0 after release; first request waits for run=1.

Source files
------------

// File: rtl/control_mc.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a ready handshake to memory.
// Enables and strobes are combinational from state and the control word latched in DECODE.
// A memory request is held until mem_rdy, or until the wait timeout sends the FSM to a sticky FAULT.
module control_mc #(
  parameter int OPW     = 4,
  parameter int NZ_BIT  = 3,
  parameter int LINK_EN = 1,
  parameter int TMO     = 255,
  parameter int TW      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic [3:0]     opfunc,
  input  logic           ctl_adata_zero,
  input  logic           mem_rdy,
  output logic           ctl_mem_req,
  output logic           ctl_mem_ifetch,
  output logic           ctl_ir_we,
  output logic           ctl_pc_we,
  output logic           ctl_alu_pc,
  output logic           ctl_alu_imm,
  output logic           ctl_regs_we,
  output logic           ctl_ram_we,
  output logic           ctl_alu_altdest,
  output logic [1:0]     ctl_wdata_src,
  output logic           ctl_branch_ind,
  output logic           ctl_branch_taken,
  output logic           ctl_fault,
  output logic [2:0]     state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // Control word captured once per instruction; ALU ops are the case where no class bit is set.
  typedef struct packed {
    logic       alu_pc;
    logic       alu_imm;
    logic       altdest;
    logic [1:0] wdata_src;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       ind;
  } cword_t;

  // Last wait cycle before the timeout fires; the fault happens after exactly TMO unanswered cycles.
  localparam logic [TW-1:0] TMO_LAST = (TMO > 0) ? TW'(TMO - 1) : '0;

  state_t         st;
  cword_t         cw;
  cword_t         dec;
  logic           dec_illegal;
  logic [TW-1:0]  tcnt;
  logic           fetch_busy;
  logic           fetch_req;
  logic           mem_req_i;
  logic           tmo_hit;
  logic           in_exec_br;
  logic           unused_opfunc;

  // Only the branch-polarity bit of opfunc matters to this block.
  assign unused_opfunc = ^opfunc;

  // Opcode decode into the control word that DECODE latches.
  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    dec.ind     = opcode[0];
    case (opcode)
      OPW'(0): ;
      OPW'(1): begin
        dec.alu_imm = 1'b1;
        dec.altdest = 1'b1;
      end
      OPW'(2): begin
        dec.alu_imm   = 1'b1;
        dec.altdest   = 1'b1;
        dec.wdata_src = 2'b01;
        dec.is_load   = 1'b1;
      end
      OPW'(3): begin
        dec.alu_imm  = 1'b1;
        dec.is_store = 1'b1;
      end
      OPW'(4): begin
        dec.alu_pc    = 1'b1;
        dec.alu_imm   = 1'b1;
        dec.altdest   = 1'b1;
        dec.wdata_src = 2'b10;
        dec.is_branch = 1'b1;
      end
      OPW'(5): begin
        dec.alu_pc    = 1'b1;
        dec.altdest   = 1'b1;
        dec.wdata_src = 2'b10;
        dec.is_branch = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Once a fetch is issued it stays issued even if run drops; run only gates starting one.
  assign fetch_req  = (st == S_FETCH) && (run || fetch_busy);
  assign mem_req_i  = fetch_req || (st == S_MEM);
  assign tmo_hit    = (TMO != 0) && mem_req_i && !mem_rdy && (tcnt == TMO_LAST);
  assign in_exec_br = (st == S_EXEC) && cw.is_branch;

  // Instruction sequencing FSM and control word latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= S_FETCH;
      cw <= '0;
    end else begin
      case (st)
        S_FETCH: begin
          if (mem_req_i && mem_rdy) st <= S_DECODE;
          else if (tmo_hit)         st <= S_FAULT;
        end
        S_DECODE: begin
          cw <= dec;
          st <= dec_illegal ? S_FAULT : S_EXEC;
        end
        S_EXEC: begin
          if (cw.is_branch)                  st <= S_FETCH;
          else if (cw.is_load || cw.is_store) st <= S_MEM;
          else                               st <= S_WB;
        end
        S_MEM: begin
          if (mem_rdy)      st <= cw.is_load ? S_WB : S_FETCH;
          else if (tmo_hit) st <= S_FAULT;
        end
        S_WB:    st <= S_FETCH;
        S_FAULT: st <= S_FAULT;
        default: st <= S_FAULT;
      endcase
    end
  end

  // Wait counter and outstanding-fetch flag; both clear whenever the request completes or ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt       <= '0;
      fetch_busy <= 1'b0;
    end else begin
      if ((TMO != 0) && mem_req_i && !mem_rdy && !tmo_hit) tcnt <= tcnt + 1'b1;
      else                                                  tcnt <= '0;
      fetch_busy <= fetch_req && !mem_rdy && !tmo_hit;
    end
  end

  // Enables and strobes; forced low while reset is asserted so an abandoned cycle writes nothing.
  assign ctl_mem_req      = rst_n && mem_req_i;
  assign ctl_mem_ifetch   = rst_n && fetch_req;
  assign ctl_ir_we        = rst_n && fetch_req && mem_rdy;
  assign ctl_pc_we        = rst_n && (in_exec_br
                                      || ((st == S_MEM) && cw.is_store && mem_rdy)
                                      || (st == S_WB));
  assign ctl_regs_we      = rst_n && ((in_exec_br && (LINK_EN != 0)) || (st == S_WB));
  assign ctl_ram_we       = rst_n && (st == S_MEM) && cw.is_store;
  assign ctl_branch_ind   = rst_n && in_exec_br && cw.ind;
  assign ctl_branch_taken = rst_n && in_exec_br && (ctl_adata_zero != opfunc[NZ_BIT]);
  assign ctl_fault        = (st == S_FAULT);

  // Datapath selects come straight from the latched word.
  assign ctl_alu_pc      = cw.alu_pc;
  assign ctl_alu_imm     = cw.alu_imm;
  assign ctl_alu_altdest = cw.altdest;
  assign ctl_wdata_src   = cw.wdata_src;
  assign state           = st;

endmodule

// File: tb/tb_control_mc.sv
// Bench for control_mc: per-cycle expected traces built from instruction-level rules.
module tb_control_mc;

  localparam int TMO_T = 4;
  localparam logic [16:0] FULL = 17'h1FFFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [3:0] opfunc = 4'd0;
  logic       adz = 1'b0;
  logic       mem_rdy = 1'b0;

  logic ctl_mem_req, ctl_mem_ifetch, ctl_ir_we, ctl_pc_we, ctl_alu_pc, ctl_alu_imm;
  logic ctl_regs_we, ctl_ram_we, ctl_alu_altdest, ctl_branch_ind, ctl_branch_taken, ctl_fault;
  logic [1:0] ctl_wdata_src;
  logic [2:0] state;

  always #5 clk = ~clk;

  control_mc #(.OPW(4), .NZ_BIT(3), .LINK_EN(1), .TMO(TMO_T), .TW(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .opfunc(opfunc),
    .ctl_adata_zero(adz), .mem_rdy(mem_rdy),
    .ctl_mem_req(ctl_mem_req), .ctl_mem_ifetch(ctl_mem_ifetch), .ctl_ir_we(ctl_ir_we),
    .ctl_pc_we(ctl_pc_we), .ctl_alu_pc(ctl_alu_pc), .ctl_alu_imm(ctl_alu_imm),
    .ctl_regs_we(ctl_regs_we), .ctl_ram_we(ctl_ram_we), .ctl_alu_altdest(ctl_alu_altdest),
    .ctl_wdata_src(ctl_wdata_src), .ctl_branch_ind(ctl_branch_ind),
    .ctl_branch_taken(ctl_branch_taken), .ctl_fault(ctl_fault), .state(state)
  );

  // {state, req, ifetch, ir_we, pc_we, regs_we, ram_we, fault, alu_pc, alu_imm, altdest, wsrc, ind, taken}
  wire [16:0] dut_vec = {state, ctl_mem_req, ctl_mem_ifetch, ctl_ir_we, ctl_pc_we, ctl_regs_we,
                         ctl_ram_we, ctl_fault, ctl_alu_pc, ctl_alu_imm, ctl_alu_altdest,
                         ctl_wdata_src, ctl_branch_ind, ctl_branch_taken};

  typedef struct {
    logic        run;
    logic [3:0]  op;
    logic [3:0]  fn;
    logic        adz;
    logic        rdy;
    logic [16:0] exp;
    logic [16:0] msk;
  } rec_t;

  rec_t q[$];
  rec_t tbl[5];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic [16:0] ev(input int st, input bit req, ifc, ir, pc, rg, ram, flt,
                                     input logic [4:0] sel, input logic [1:0] br);
    return {3'(st), req, ifc, ir, pc, rg, ram, flt, sel, br};
  endfunction

  // Selects are defined from EXEC through WB; ifetch only while a request is up; ind/taken in branch EXEC.
  function automatic logic [16:0] mk(input bit req, input bit chk_sel, input bit chk_br);
    logic [16:0] m;
    m = 17'h1FF80;
    if (!req)   m[12] = 1'b0;
    if (chk_sel) m = m | 17'h0007C;
    if (chk_br)  m = m | 17'h00003;
    return m;
  endfunction

  // {alu_pc, alu_imm, altdest, wdata_src} per opcode.
  function automatic logic [4:0] sel_of(input logic [3:0] op);
    case (op)
      4'd0:    return 5'b000_00;
      4'd1:    return 5'b011_00;
      4'd2:    return 5'b011_01;
      4'd3:    return 5'b010_00;
      4'd4:    return 5'b111_10;
      4'd5:    return 5'b101_10;
      default: return 5'b000_00;
    endcase
  endfunction

  task automatic check(input string nm, input logic [16:0] got, input logic [16:0] exp,
                       input logic [16:0] msk);
    n_chk++;
    if (((got ^ exp) & msk) != 17'd0) begin
      n_fail++;
      $display("FAIL %s: got %05h required %05h (mask %05h)", nm, got, exp, msk);
    end
  endtask

  task automatic push(input logic rn, input logic [3:0] op, input logic [3:0] fn,
                      input logic az, input logic rdy, input logic [16:0] e, input logic [16:0] m);
    rec_t r;
    r.run = rn; r.op = op; r.fn = fn; r.adz = az; r.rdy = rdy; r.exp = e; r.msk = m;
    q.push_back(r);
  endtask

  task automatic push_fault(input int n);
    for (int i = 0; i < n; i++)
      push(rnd1(), rnd4(), rnd4(), rnd1(), rnd1(), ev(5, 0, 0, 0, 0, 0, 0, 1, 5'd0, 2'd0), mk(0, 0, 0));
  endtask

  // Expected cycle trace of one instruction: pre idle cycles (run=0), f fetch waits, m mem waits.
  task automatic gen_insn(input logic [3:0] op, input logic [3:0] fn, input logic az,
                          input int f, input int m, input int pre, output bit flt);
    logic [4:0] sel;
    bit         is_st;
    bit         is_br;
    sel   = sel_of(op);
    is_st = (op == 4'd3);
    is_br = (op == 4'd4) || (op == 4'd5);
    flt   = 1'b0;
    for (int i = 0; i < pre; i++)
      push(1'b0, rnd4(), rnd4(), rnd1(), rnd1(), ev(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 2'd0), mk(0, 0, 0));
    for (int i = 0; i < f && i < TMO_T; i++)
      push((i == 0) ? 1'b1 : rnd1(), rnd4(), rnd4(), rnd1(), 1'b0,
           ev(0, 1, 1, 0, 0, 0, 0, 0, 5'd0, 2'd0), mk(1, 0, 0));
    if (f >= TMO_T) begin
      push_fault(3);
      flt = 1'b1;
      return;
    end
    push((f == 0) ? 1'b1 : rnd1(), rnd4(), rnd4(), rnd1(), 1'b1,
         ev(0, 1, 1, 1, 0, 0, 0, 0, 5'd0, 2'd0), mk(1, 0, 0));
    push(rnd1(), op, fn, az, rnd1(), ev(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 2'd0), mk(0, 0, 0));
    if (op > 4'd5) begin
      push_fault(3);
      flt = 1'b1;
      return;
    end
    if (is_br)
      push(rnd1(), op, fn, az, rnd1(),
           ev(2, 0, 0, 0, 1, 1, 0, 0, sel, {op[0], az != fn[3]}), mk(0, 1, 1));
    else
      push(rnd1(), op, fn, az, rnd1(), ev(2, 0, 0, 0, 0, 0, 0, 0, sel, 2'd0), mk(0, 1, 0));
    if (op == 4'd2 || op == 4'd3) begin
      for (int i = 0; i < m && i < TMO_T; i++)
        push(rnd1(), op, fn, az, 1'b0, ev(3, 1, 0, 0, 0, 0, is_st, 0, sel, 2'd0), mk(1, 1, 0));
      if (m >= TMO_T) begin
        push_fault(3);
        flt = 1'b1;
        return;
      end
      push(rnd1(), op, fn, az, 1'b1, ev(3, 1, 0, 0, is_st, 0, is_st, 0, sel, 2'd0), mk(1, 1, 0));
    end
    if (op <= 4'd2)
      push(rnd1(), op, fn, az, rnd1(), ev(4, 0, 0, 0, 1, 1, 0, 0, sel, 2'd0), mk(0, 1, 0));
  endtask

  // Entered and left just after a rising edge; outputs compared on the falling edge.
  task automatic apply(input rec_t r, input string nm);
    run = r.run; opcode = r.op; opfunc = r.fn; adz = r.adz; mem_rdy = r.rdy;
    @(negedge clk);
    check(nm, dut_vec, r.exp, r.msk);
    @(posedge clk);
    #1;
  endtask

  task automatic run_q(input string nm, input int n);
    int lim;
    lim = (n < 0 || n > q.size()) ? q.size() : n;
    for (int i = 0; i < lim; i++) apply(q[i], $sformatf("%s[%0d]", nm, i));
    q.delete();
  endtask

  // Asynchronous reset pulse mid-cycle with run and mem_rdy high: everything must drop at once.
  task automatic do_reset(input string nm);
    run = 1'b1; mem_rdy = 1'b1;
    #2 rst_n = 1'b0;
    #1 check(nm, dut_vec, 17'd0, FULL);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit flt;
    // ALU reg op with memory always ready: states 0,1,2,4,0.
    tbl[0] = '{1'b1, 4'd0, 4'd0, 1'b0, 1'b1, ev(0, 1, 1, 1, 0, 0, 0, 0, 5'd0, 2'd0), mk(1, 0, 0)};
    tbl[1] = '{1'b1, 4'd0, 4'd0, 1'b0, 1'b1, ev(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 2'd0), mk(0, 0, 0)};
    tbl[2] = '{1'b1, 4'd0, 4'd0, 1'b0, 1'b1, ev(2, 0, 0, 0, 0, 0, 0, 0, 5'd0, 2'd0), mk(0, 1, 0)};
    tbl[3] = '{1'b1, 4'd0, 4'd0, 1'b0, 1'b1, ev(4, 0, 0, 0, 1, 1, 0, 0, 5'd0, 2'd0), mk(0, 1, 0)};
    tbl[4] = '{1'b1, 4'd0, 4'd0, 1'b0, 1'b1, ev(0, 1, 1, 1, 0, 0, 0, 0, 5'd0, 2'd0), mk(1, 0, 0)};

    rst_n = 1'b0; run = 1'b1; mem_rdy = 1'b1;
    #3 check("reset_hold", dut_vec, 17'd0, FULL);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) apply(tbl[i], $sformatf("alu_tbl[%0d]", i));
    do_reset("rst_after_alu");

    // LW with three MEM wait cycles.
    gen_insn(4'd2, 4'd0, 1'b0, 0, 3, 0, flt);
    run_q("lw_wait", -1);
    do_reset("rst_after_lw");

    // Branch-if-nonzero, taken then not taken.
    gen_insn(4'd4, 4'b1000, 1'b0, 0, 0, 0, flt);
    gen_insn(4'd4, 4'b1000, 1'b1, 0, 0, 0, flt);
    gen_insn(4'd5, 4'b0000, 1'b1, 1, 0, 0, flt);
    run_q("branch", -1);
    do_reset("rst_after_br");

    // Fetch timeout, then a late mem_rdy that must not leave FAULT.
    gen_insn(4'd0, 4'd0, 1'b0, TMO_T, 0, 0, flt);
    for (int i = 0; i < 3; i++)
      push(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, ev(5, 0, 0, 0, 0, 0, 0, 1, 5'd0, 2'd0), mk(0, 0, 0));
    run_q("fetch_tmo", -1);
    do_reset("rst_after_tmo");

    // Illegal opcode.
    gen_insn(4'hF, 4'd0, 1'b0, 0, 0, 0, flt);
    run_q("illegal", -1);
    do_reset("rst_after_ill");

    // SW held in MEM, asynchronous reset in the middle of a wait cycle.
    gen_insn(4'd3, 4'd0, 1'b0, 0, 3, 0, flt);
    run_q("sw_pre", 4);
    run = 1'b0; mem_rdy = 1'b0;
    #1 check("sw_mem_held", dut_vec, ev(3, 1, 0, 0, 0, 0, 1, 0, 5'd0, 2'd0), mk(1, 0, 0));
    #1 rst_n = 1'b0;
    #1 check("sw_async_rst", dut_vec, 17'd0, FULL);
    @(posedge clk);
    #1 rst_n = 1'b1;
    gen_insn(4'd1, 4'd0, 1'b0, 0, 0, 3, flt);
    run_q("after_sw_rst", -1);

    // Random instruction stream.
    for (int k = 0; k < 200; k++) begin
      logic [3:0] op;
      int f, m, pre;
      op  = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      f   = ($urandom_range(0, 19) == 0) ? TMO_T : int'($urandom_range(0, 3));
      m   = ($urandom_range(0, 19) == 0) ? TMO_T : int'($urandom_range(0, 3));
      pre = int'($urandom_range(0, 2));
      gen_insn(op, rnd4(), rnd1(), f, m, pre, flt);
      run_q($sformatf("rnd%0d", k), -1);
      if (flt) do_reset($sformatf("rnd_rst%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
